// File: rtl/dmem_ctrl_pkg.sv
// Shared constants and types for the PE data-memory controller blocks.
package dmem_ctrl_pkg;

    localparam int DMEM_ADDR_W = 5;
    localparam int DMEM_DATA_W = 512;
    localparam int DMEM_DEPTH  = 32;

    typedef enum logic {
        S_IDLE,
        S_FILL
    } sched_state_e;

endpackage

// File: rtl/dmem_write_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant scanning upward from a rotating pointer;
// the pointer advances past the winner and holds when nothing is granted.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                       CLK,
    input  logic                       MEMRST,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       enable,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       grant_vld
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0] ptr_q, ptr_d;

    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        ptr_d     = ptr_q;
        if (enable) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (int'(ptr_q) + k) % NUM_REQ;
                if (!grant_vld && req[idx]) begin
                    grant_vld  = 1'b1;
                    grant[idx] = 1'b1;
                    grant_idx  = PTR_W'(idx);
                    ptr_d      = (idx == NUM_REQ - 1) ? '0 : PTR_W'(idx + 1);
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge MEMRST) begin
        if (!MEMRST) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/dmem_write_scheduler.sv
// Write-port scheduler for the PE data memory: round-robin requester writes plus
// a preempting range fill. Optional DMEM_SCHED_STATS_EN adds per-requester grant counters.
module dmem_write_scheduler
    import dmem_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = DMEM_ADDR_W,
    parameter int DATA_W  = DMEM_DATA_W
) (
    input  logic                        CLK,
    input  logic                        MEMRST,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic                        fill_start,
    input  logic [ADDR_W-1:0]           fill_lo,
    input  logic [ADDR_W-1:0]           fill_hi,
    input  logic [DATA_W-1:0]           fill_data,
    output logic                        fill_busy,
    output logic                        fill_done,
    output logic                        fill_err,
    output logic                        mem_cs,
    output logic                        mem_we,
    output logic                        mem_oe,
    output logic [ADDR_W-1:0]           mem_in_addr,
    output logic [DATA_W-1:0]           mem_data_in,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id
`ifdef DMEM_SCHED_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]       grant_cnt
`endif
);

    localparam int ID_W = $clog2(NUM_REQ);

    sched_state_e      state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [ADDR_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] fdata_q, fdata_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ID_W-1:0]   gid_q, gid_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              oe_q;

    logic              fill_ok;
    logic              arb_en;
    logic [ID_W-1:0]   grant_idx;
    logic              grant_vld;

    // A valid fill request in IDLE wins over any simultaneous requester.
    assign fill_ok = fill_start && (fill_lo <= fill_hi);
    assign arb_en  = MEMRST && (state_q == S_IDLE) && !fill_ok;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .CLK       (CLK),
        .MEMRST    (MEMRST),
        .req       (req_valid),
        .enable    (arb_en),
        .grant     (req_ready),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        hi_d    = hi_q;
        fdata_d = fdata_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        gid_d   = gid_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fill_start) begin
                    if (fill_ok) begin
                        state_d = S_FILL;
                        cur_d   = fill_lo;
                        hi_d    = fill_hi;
                        fdata_d = fill_data;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (grant_vld) begin
                    we_d   = 1'b1;
                    addr_d = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
                    data_d = req_data[int'(grant_idx)*DATA_W +: DATA_W];
                    gid_d  = grant_idx;
                end
            end
            S_FILL: begin
                we_d   = 1'b1;
                addr_d = cur_q;
                data_d = fdata_q;
                gid_d  = '0;
                // Compare before incrementing so hi at the top of the range never wraps.
                if (cur_q == hi_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cur_d = cur_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge MEMRST) begin
        if (!MEMRST) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
            hi_q    <= '0;
            fdata_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            gid_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            hi_q    <= hi_d;
            fdata_q <= fdata_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            gid_q   <= gid_d;
            done_q  <= done_d;
            err_q   <= err_d;
            oe_q    <= 1'b1;
        end
    end

    assign fill_busy   = (state_q == S_FILL);
    assign fill_done   = done_q;
    assign fill_err    = err_q;
    assign mem_we      = we_q;
    assign mem_oe      = oe_q;
    assign mem_cs      = we_q | oe_q;
    assign mem_in_addr = addr_q;
    assign mem_data_in = data_q;
    assign grant_id    = gid_q;

`ifdef DMEM_SCHED_STATS_EN
    logic [NUM_REQ-1:0][15:0] cnt_q, cnt_d;

    // Counters saturate rather than wrap so long runs still read as "busy".
    always_comb begin
        cnt_d = cnt_q;
        if (grant_vld && (cnt_q[grant_idx] != 16'hFFFF)) begin
            cnt_d[grant_idx] = cnt_q[grant_idx] + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge MEMRST) begin
        if (!MEMRST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_dmem_write_scheduler.sv
// Testbench for dmem_write_scheduler: directed scenarios with literal expectations
// plus randomized traffic against a cycle-level behavioural model.
module tb_dmem_write_scheduler;

    localparam int N  = 4;
    localparam int AW = 5;
    localparam int DW = 512;

    logic              CLK;
    logic              MEMRST;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_data;
    logic              fill_start;
    logic [AW-1:0]     fill_lo;
    logic [AW-1:0]     fill_hi;
    logic [DW-1:0]     fill_data;
    logic              fill_busy;
    logic              fill_done;
    logic              fill_err;
    logic              mem_cs;
    logic              mem_we;
    logic              mem_oe;
    logic [AW-1:0]     mem_in_addr;
    logic [DW-1:0]     mem_data_in;
    logic [1:0]        grant_id;
`ifdef DMEM_SCHED_STATS_EN
    logic [N*16-1:0]   grant_cnt;
`endif

    dmem_write_scheduler #(
        .NUM_REQ (N),
        .ADDR_W  (AW),
        .DATA_W  (DW)
    ) dut (
        .CLK         (CLK),
        .MEMRST      (MEMRST),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .fill_start  (fill_start),
        .fill_lo     (fill_lo),
        .fill_hi     (fill_hi),
        .fill_data   (fill_data),
        .fill_busy   (fill_busy),
        .fill_done   (fill_done),
        .fill_err    (fill_err),
        .mem_cs      (mem_cs),
        .mem_we      (mem_we),
        .mem_oe      (mem_oe),
        .mem_in_addr (mem_in_addr),
        .mem_data_in (mem_data_in),
        .grant_id    (grant_id)
`ifdef DMEM_SCHED_STATS_EN
        ,
        .grant_cnt   (grant_cnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state: what the memory pins must show after the next edge.
    int            m_ptr;
    bit            m_fill;
    logic [AW-1:0] m_cur, m_hi;
    logic [DW-1:0] m_fdata;
    bit            e_we, e_done, e_err, e_oe, e_gid_chk;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    int            e_gid;
    logic [N-1:0]  rdy_s;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int k = 0; k < DW/32; k++) w[k*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic logic [N-1:0] model_ready();
        int i;
        if (MEMRST !== 1'b1 || m_fill) return '0;
        if (fill_start && (fill_lo <= fill_hi)) return '0;
        for (int k = 0; k < N; k++) begin
            i = (m_ptr + k) % N;
            if (req_valid[i]) return N'(1) << i;
        end
        return '0;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_fill = 0; m_cur = '0; m_hi = '0; m_fdata = '0;
        e_we = 0; e_done = 0; e_err = 0; e_oe = 0; e_gid_chk = 0;
        e_addr = '0; e_data = '0; e_gid = 0;
    endtask

    task automatic model_step();
        logic [N-1:0] r;
        r = model_ready();
        e_oe = 1; e_we = 0; e_done = 0; e_err = 0; e_gid_chk = 0;
        if (m_fill) begin
            e_we = 1; e_addr = m_cur; e_data = m_fdata;
            if (m_cur == m_hi) begin
                m_fill = 0; e_done = 1;
            end else begin
                m_cur = m_cur + 1'b1;
            end
        end else begin
            if (fill_start) begin
                if (fill_lo <= fill_hi) begin
                    m_fill = 1; m_cur = fill_lo; m_hi = fill_hi; m_fdata = fill_data;
                end else begin
                    e_err = 1;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (r[i]) begin
                    e_we = 1; e_gid_chk = 1; e_gid = i;
                    e_addr = req_addr[i*AW +: AW];
                    e_data = req_data[i*DW +: DW];
                    m_ptr = (i + 1) % N;
                end
            end
        end
    endtask

    // One clock cycle: check combinational outputs mid-cycle, advance the model
    // on the edge, then check registered outputs just after it.
    task automatic tick();
        @(negedge CLK);
        rdy_s = req_ready;
        chk("req_ready", req_ready, model_ready());
        chk("fill_busy", fill_busy, m_fill);
        @(posedge CLK);
        model_step();
        #1;
        chk("mem_we", mem_we, e_we);
        chk("mem_oe", mem_oe, e_oe);
        chk("mem_cs", mem_cs, e_we | e_oe);
        chk("fill_done", fill_done, e_done);
        chk("fill_err", fill_err, e_err);
        if (e_we) begin
            chk("mem_in_addr", mem_in_addr, e_addr);
            chk("mem_data_in", mem_data_in, e_data);
            if (e_gid_chk) chk("grant_id", grant_id, e_gid);
        end
    endtask

    task automatic hw_reset();
        MEMRST = 1'b0;
        model_reset();
        req_valid = '1; fill_start = 1'b0;
        @(posedge CLK);
        #1;
        chk("rst_we", mem_we, 0);
        chk("rst_oe", mem_oe, 0);
        chk("rst_cs", mem_cs, 0);
        chk("rst_busy", fill_busy, 0);
        chk("rst_done", fill_done, 0);
        chk("rst_err", fill_err, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_addr", mem_in_addr, 0);
        chk("rst_data", mem_data_in, 0);
        chk("rst_gid", grant_id, 0);
        req_valid = '0;
        #1 MEMRST = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] w;
        MEMRST = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
        fill_start = 1'b0; fill_lo = '0; fill_hi = '0; fill_data = '0;
        model_reset();
        #2;
        hw_reset();

        // First edge after release raises mem_oe.
        tick();
        chk("oe_after_release", mem_oe, 1);

        // Single write from requester 0.
        req_addr[0 +: AW] = 5'd3;
        req_data[0 +: DW] = {64{8'hA5}};
        req_valid = 4'b0001;
        tick();
        chk("single_ready", rdy_s, 4'b0001);
        chk("single_we", mem_we, 1);
        chk("single_addr", mem_in_addr, 3);
        chk("single_gid", grant_id, 0);
        chk("single_data", mem_data_in, {64{8'hA5}});
        req_valid = '0;
        tick();
        chk("single_we_off", mem_we, 0);

        // All four held valid: strict rotation from a fresh pointer.
        hw_reset();
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW] = AW'(10 + i);
            req_data[i*DW +: DW] = rand_word();
        end
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rr_order", grant_id, k % 4);
            chk("rr_we", mem_we, 1);
            chk("rr_addr", mem_in_addr, 10 + (k % 4));
        end
        req_valid = '0;
        tick();

        // Fill 28..31 preempting requester 1.
        hw_reset();
        req_addr[1*AW +: AW] = 5'd9;
        req_valid = 4'b0010;
        fill_lo = 5'd28; fill_hi = 5'd31; fill_data = {DW{1'b1}};
        fill_start = 1'b1;
        tick();
        chk("fill_start_ready", rdy_s, 0);
        fill_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("fill_ready", rdy_s, 0);
            chk("fill_we", mem_we, 1);
            chk("fill_addr", mem_in_addr, 28 + k);
            chk("fill_data", mem_data_in, {DW{1'b1}});
            chk("fill_done_pulse", fill_done, (k == 3) ? 1 : 0);
        end
        chk("fill_busy_end", fill_busy, 0);
        tick();
        chk("post_fill_ready", rdy_s, 4'b0010);
        chk("post_fill_gid", grant_id, 1);
        chk("post_fill_addr", mem_in_addr, 9);
        chk("post_fill_done_off", fill_done, 0);
        req_valid = '0;
        tick();

        // Rejected fill (lo > hi) without and with a simultaneous request.
        fill_lo = 5'd7; fill_hi = 5'd2; fill_start = 1'b1;
        tick();
        chk("err_pulse", fill_err, 1);
        chk("err_no_we", mem_we, 0);
        chk("err_busy", fill_busy, 0);
        fill_start = 1'b0;
        tick();
        chk("err_clear", fill_err, 0);
        chk("err_busy2", fill_busy, 0);
        req_addr[3*AW +: AW] = 5'd17;
        req_valid = 4'b1000;
        fill_start = 1'b1;
        tick();
        chk("err_req_ready", rdy_s, 4'b1000);
        chk("err_req_pulse", fill_err, 1);
        chk("err_req_addr", mem_in_addr, 17);
        fill_start = 1'b0; req_valid = '0;
        tick();

        // Reset asserted in the second fill cycle.
        fill_lo = 5'd0; fill_hi = 5'd10; fill_data = rand_word(); fill_start = 1'b1;
        req_valid = 4'b0100;
        tick();
        fill_start = 1'b0;
        tick();
        chk("abort_pre_we", mem_we, 1);
        #2 MEMRST = 1'b0;
        model_reset();
        #1;
        chk("abort_we", mem_we, 0);
        chk("abort_busy", fill_busy, 0);
        chk("abort_done", fill_done, 0);
        chk("abort_oe", mem_oe, 0);
        chk("abort_cs", mem_cs, 0);
        chk("abort_ready", req_ready, 0);
        @(posedge CLK);
        #1;
        chk("abort_hold_oe", mem_oe, 0);
        chk("abort_hold_done", fill_done, 0);
        req_valid = '0;
        #1 MEMRST = 1'b1;
        tick();
        chk("abort_release_oe", mem_oe, 1);
        chk("abort_release_done", fill_done, 0);
        chk("abort_release_we", mem_we, 0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && rdy_s[i]) begin
                    if ($urandom_range(0, 1) == 0) begin
                        req_valid[i] = 1'b0;
                    end else begin
                        req_addr[i*AW +: AW] = AW'($urandom_range(0, 31));
                        req_data[i*DW +: DW] = rand_word();
                    end
                end else if (!req_valid[i] && $urandom_range(0, 9) < 4) begin
                    req_valid[i] = 1'b1;
                    req_addr[i*AW +: AW] = AW'($urandom_range(0, 31));
                    req_data[i*DW +: DW] = rand_word();
                end
            end
            fill_start = ($urandom_range(0, 39) == 0);
            fill_lo    = AW'($urandom_range(0, 31));
            fill_hi    = AW'($urandom_range(0, 31));
            fill_data  = rand_word();
            tick();
        end
        fill_start = 1'b0;
        req_valid = '0;
        tick();

`ifdef DMEM_SCHED_STATS_EN
        hw_reset();
        req_addr[2*AW +: AW] = 5'd5;
        req_valid = 4'b0100;
        for (int c = 0; c < 70000; c++) tick();
        req_valid = '0;
        tick();
        for (int i = 0; i < N; i++) begin
            chk("grant_cnt", grant_cnt[i*16 +: 16], (i == 2) ? 16'hFFFF : 16'h0000);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
